// File: rtl/ext_pipe.sv
// Registered immediate extender with valid/ready handshake and a 2-entry skid buffer.
// Modes: zero, sign, upper-load and sign-extended branch offset shifted by BR_SHIFT.
module ext_pipe #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  In,
  input  logic [1:0]       ExtOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Out
);

  localparam logic [1:0] OpZero  = 2'b00;
  localparam logic [1:0] OpSign  = 2'b01;
  localparam logic [1:0] OpUpper = 2'b10;
  localparam logic [1:0] OpBr    = 2'b11;

  logic             or_valid_q, or_valid_d;
  logic [OUT_W-1:0] or_data_q,  or_data_d;
  logic             sk_valid_q, sk_valid_d;
  logic [OUT_W-1:0] sk_data_q,  sk_data_d;

  logic             accept;
  logic             take;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_val;

  // Extension datapath; only captured on accept, so X inputs while idle never reach state.
  always_comb begin
    zext    = OUT_W'(In);
    sext    = OUT_W'($signed(In));
    ext_val = zext;
    case (ExtOp)
      OpZero:  ext_val = zext;
      OpSign:  ext_val = sext;
      OpUpper: ext_val = zext << (OUT_W - IN_W);
      OpBr:    ext_val = sext << BR_SHIFT;
      default: ext_val = zext;
    endcase
  end

  assign in_ready  = ~sk_valid_q;
  assign out_valid = or_valid_q;
  assign Out       = or_data_q;
  assign accept    = in_valid & in_ready;
  assign take      = or_valid_q & out_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || take) begin
      // Skid entry is older than anything arriving now, so it drains first.
      if (sk_valid_q) begin
        or_data_d  = sk_data_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        or_data_d  = ext_val;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_data_d  = ext_val;
      sk_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: modes, streaming, back-pressure, flush, async reset,
// plus a narrow 8->16 instance.
module tb_ext_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  ext_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic [1:0]  ext_op8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] out_data8;

  int checks;
  int errors;

  ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (in_data),
    .ExtOp     (ext_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (out_data)
  );

  ext_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .In        (in_data8),
    .ExtOp     (ext_op8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .Out       (out_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out: got %h want 00000000", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_modes();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h00008001;
    exp_tab[1] = 32'hFFFF8001;
    exp_tab[2] = 32'h80010000;
    exp_tab[3] = 32'hFFFE0004;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1;
      in_data  = 16'h8001;
      ext_op   = 2'(m);
      step();
      in_valid = 1'b0;
      in_data  = 'x;
      ext_op   = 'x;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[m]) begin
        errors++;
        $display("FAIL mode%0d: got valid=%b out=%h want valid=1 out=%h",
                 m, out_valid, out_data, exp_tab[m]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mode_idle_x: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [4];
    logic [1:0]  ops [4];
    logic [31:0] dexp [4];
    din[0] = 16'h0001; ops[0] = 2'b01; dexp[0] = 32'h00000001;
    din[1] = 16'h7FFF; ops[1] = 2'b01; dexp[1] = 32'h00007FFF;
    din[2] = 16'hFFFF; ops[2] = 2'b01; dexp[2] = 32'hFFFFFFFF;
    din[3] = 16'h1234; ops[3] = 2'b00; dexp[3] = 32'h00001234;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = din[i];
      ext_op   = ops[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready%0d: got %b want 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== dexp[i]) begin
        errors++;
        $display("FAIL stream%0d: got valid=%b out=%h want valid=1 out=%h",
                 i, out_valid, out_data, dexp[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    ext_op    = 2'b00;
    in_valid  = 1'b1; in_data = 16'h00AA;
    step();
    in_data = 16'h00BB;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_a: got %b want 1", in_ready);
    end
    step();
    in_data = 16'h00CC;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h000000AA) begin
      errors++;
      $display("FAIL bp_full: got ready=%b valid=%b out=%h want ready=0 valid=1 out=000000aa",
               in_ready, out_valid, out_data);
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'h000000AA) begin
      errors++;
      $display("FAIL bp_hold: got ready=%b out=%h want ready=0 out=000000aa", in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h000000BB || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain_b: got valid=%b out=%h ready=%b want valid=1 out=000000bb ready=1",
               out_valid, out_data, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h000000CC) begin
      errors++;
      $display("FAIL bp_drain_c: got valid=%b out=%h want valid=1 out=000000cc",
               out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    ext_op    = 2'b00;
    in_valid  = 1'b1; in_data = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    flush = 1'b1; in_data = 16'h00DD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h00EE;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_accept: got valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1; in_data = 16'h0033;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000033) begin
      errors++;
      $display("FAIL flush_after: got valid=%b out=%h want valid=1 out=00000033",
               out_valid, out_data);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    ext_op    = 2'b01;
    in_valid  = 1'b1; in_data = 16'h8000;
    step();
    in_data = 16'h4000;
    step();
    in_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got valid=%b out=%h ready=%b want valid=0 out=00000000 ready=1",
               out_valid, out_data, in_ready);
    end
    #1 reset = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_data = 16'h0F0F; ext_op = 2'b10;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0F0F0000) begin
      errors++;
      $display("FAIL after_reset: got valid=%b out=%h want valid=1 out=0f0f0000",
               out_valid, out_data);
    end
    step();
  endtask

  task automatic test_narrow();
    logic [1:0]  ops [3];
    logic [15:0] dexp [3];
    ops[0] = 2'b11; dexp[0] = 16'hFF80;
    ops[1] = 2'b10; dexp[1] = 16'hC000;
    ops[2] = 2'b01; dexp[2] = 16'hFFC0;
    out_ready8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid8 = 1'b1;
      in_data8  = 8'hC0;
      ext_op8   = ops[i];
      step();
      in_valid8 = 1'b0;
      checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== dexp[i]) begin
        errors++;
        $display("FAIL narrow%0d: got valid=%b out=%h want valid=1 out=%h",
                 i, out_valid8, out_data8, dexp[i]);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    ext_op     = '0;
    out_ready  = 1'b0;
    in_valid8  = 1'b0;
    in_data8   = '0;
    ext_op8    = '0;
    out_ready8 = 1'b0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1);
  end

endmodule
